// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the shared MIPS datapath.
// The controller owns the master side; the datapath (or a bench) owns the slave side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwrite_eq;
  logic             pcwrite_ne;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrc_a;
  logic [1:0]       alusrc_b;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwrite_eq, pcwrite_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrc_a, alusrc_b, aluop, pcsource,
           illegal, instret, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwrite_eq, pcwrite_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrc_a, alusrc_b, aluop, pcsource,
           illegal, instret, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback, stalls on mem_ready, counts retirements and flags bad opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           state_reg;
  state_t           state_next;
  logic [5:0]       opcode_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      opcode_reg  <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        opcode_reg <= bus.opcode;
      end
      if (retire) begin
        instret_reg <= instret_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    retire         = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.pcwrite_eq = 1'b0;
    bus.pcwrite_ne = 1'b0;
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrc_a   = 1'b0;
    bus.alusrc_b   = 2'd0;
    bus.aluop      = 2'b00;
    bus.pcsource   = 2'd0;
    bus.illegal    = 1'b0;

    case (state_reg)
      FETCH: begin
        bus.memread  = 1'b1;
        bus.alusrc_b = 2'd1;
        // PC+4 and IR only commit once memory delivers the instruction word
        if (bus.mem_ready) begin
          bus.pcwrite = 1'b1;
          bus.irwrite = 1'b1;
          state_next  = DECODE;
        end
      end
      DECODE: begin
        bus.alusrc_b = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW:   state_next = MEMADR;
          OP_RTYPE:       state_next = EXEC;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_J:           state_next = JUMP;
          OP_ADDI:        state_next = IEXEC;
          default: begin
            state_next  = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = 2'd2;
        state_next   = (opcode_reg == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_next = MEMWB;
        end
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      EXEC: begin
        bus.alusrc_a = 1'b1;
        bus.aluop    = 2'b10;
        state_next   = RWB;
      end
      RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      BRANCH: begin
        bus.alusrc_a   = 1'b1;
        bus.aluop      = 2'b01;
        bus.pcsource   = 2'd1;
        bus.pcwrite_eq = (opcode_reg == OP_BEQ);
        bus.pcwrite_ne = (opcode_reg == OP_BNE);
        state_next     = FETCH;
        retire         = 1'b1;
      end
      JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'd2;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      IEXEC: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = 2'd2;
        state_next   = IWB;
      end
      IWB: begin
        bus.regwrite = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // Reset silences every strobe so an abandoned instruction writes nothing
    if (rst) begin
      retire         = 1'b0;
      bus.pcwrite    = 1'b0;
      bus.pcwrite_eq = 1'b0;
      bus.pcwrite_ne = 1'b0;
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdst     = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrc_a   = 1'b0;
      bus.alusrc_b   = 2'd0;
      bus.aluop      = 2'b00;
      bus.pcsource   = 2'd0;
      bus.illegal    = 1'b0;
    end
  end

  assign bus.state   = state_reg;
  assign bus.instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/strobes/count are
// queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
  multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.master));

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt  = 0;
  int          txn_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Expected strobes for a state, packed in the same field order as actual_ctrl()
  function automatic logic [17:0] exp_ctrl(input int st, input logic ready, input logic [5:0] op);
    logic pw, peq, pne, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pw, peq, pne, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      0:  begin mr = 1; asb = 2'd1; pw = ready; irw = ready; end
      1:  begin asb = 2'd3; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'd1; peq = (op == OP_BEQ); pne = (op == OP_BNE); end
      9:  begin pw = 1; psrc = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pw, peq, pne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic [17:0] actual_ctrl();
    return {bus.pcwrite, bus.pcwrite_eq, bus.pcwrite_ne, bus.iord, bus.memread,
            bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite,
            bus.alusrc_a, bus.alusrc_b, bus.aluop, bus.pcsource, bus.illegal};
  endfunction

  // One DUT cycle: drive inputs, queue the expectation, advance to just after the edge
  task automatic step(input int st, input logic ready, input logic [5:0] op_exp,
                      input logic [5:0] op_drive);
    exp_t e;
    bus.mem_ready = ready;
    bus.opcode    = op_drive;
    e.st   = 4'(st);
    e.ctrl = exp_ctrl(st, ready, op_exp);
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    txn_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic step_rst(input int st);
    exp_t e;
    e.st   = 4'(st);
    e.ctrl = '0;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
    txn_cycles = 0;
    for (int i = 0; i < fetch_wait; i++) step(0, 1'b0, op, op);
    step(0, 1'b1, op, op);
    step(1, 1'b1, op, op);
    case (op)
      OP_R: begin step(6, 1'b1, op, junk()); step(7, 1'b1, op, junk()); end
      OP_LW: begin
        step(2, 1'b1, op, junk());
        for (int i = 0; i < mem_wait; i++) step(3, 1'b0, op, junk());
        step(3, 1'b1, op, junk());
        step(4, 1'b1, op, junk());
      end
      OP_SW: begin
        step(2, 1'b1, op, junk());
        for (int i = 0; i < mem_wait; i++) step(5, 1'b0, op, junk());
        step(5, 1'b1, op, junk());
      end
      OP_BEQ, OP_BNE: step(8, 1'b1, op, junk());
      OP_J: step(9, 1'b1, op, junk());
      OP_ADDI: begin step(10, 1'b1, op, junk()); step(11, 1'b1, op, junk()); end
      default: ;
    endcase
    if (is_legal(op)) exp_cnt = exp_cnt + 1;
    $display("txn op=%02h cycles=%0d instret_exp=%0d", op, txn_cycles, exp_cnt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("state",    32'(bus.state),    32'(e.st));
      check("ctrl",     32'(actual_ctrl()), 32'(e.ctrl));
      check("instret",  bus.instret,       e.cnt);
      check("state4",   32'(bus4.state),   32'(e.st));
      check("instret4", 32'(bus4.instret), 32'(e.cnt[3:0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step_rst(0);
    rst = 1'b0;

    run_instr(OP_R,    0, 0);
    run_instr(OP_LW,   0, 3);
    run_instr(OP_BEQ,  0, 0);
    run_instr(OP_BNE,  0, 0);
    run_instr(OP_SW,   0, 0);
    run_instr(OP_J,    0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_BAD,  0, 0);
    run_instr(OP_SW,   2, 1);
    run_instr(OP_ADDI, 1, 0);

    // Abandon a lw while it waits in MEMRD
    txn_cycles = 0;
    step(0, 1'b1, OP_LW, OP_LW);
    step(1, 1'b1, OP_LW, OP_LW);
    step(2, 1'b1, OP_LW, junk());
    step(3, 1'b0, OP_LW, junk());
    rst = 1'b1;
    step_rst(3);
    exp_cnt = 0;
    step_rst(0);
    rst = 1'b0;
    $display("txn op=%02h reset mid-instruction instret_exp=%0d", OP_LW, exp_cnt);
    run_instr(OP_R, 0, 0);

    for (int k = 0; k < 15; k++) run_instr(OP_J, 0, 0);
    check("wrap32", bus.instret, 32'd16);
    check("wrap4",  32'(bus4.instret), 32'd0);
    run_instr(OP_BAD, 0, 0);

    @(negedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer that replaces the single-cycle decoder in the MIPS core.
- Walks each instruction through FETCH/DECODE/execute/memory/writeback states. Drives per-cycle strobes and mux selects for the shared datapath: one memory port, one ALU, register file, PC and IR.
- Stalls on a memory ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter `instret`.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; sampled in DECODE only
- mem_ready  in  1  memory accepted/completed the current access this cycle
- pcwrite  out  1  unconditional PC load
- pcwrite_eq  out  1  PC load if ALU zero (beq)
- pcwrite_ne  out  1  PC load if ALU not zero (bne)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- memtoreg  out  1  register write data select: 1 = MDR
- regdst  out  1  destination select: 1 = rd, 0 = rt
- regwrite  out  1  register file write
- alusrc_a  out  1  ALU A select: 0 = PC, 1 = rs
- alusrc_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct field
- pcsource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal  out  1  one-cycle pulse on an unrecognised opcode
- instret  out  CNT_W  retired-instruction count
- state  out  4  current state, for debug

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11
- Reset: while rst=1, state <= FETCH and instret <= 0. All strobe/select outputs are forced to 0 in that cycle. Reset asserted mid-instruction abandons it with no write.
- Outputs decode combinationally from state; unlisted outputs are 0.
- FETCH:
  - Drives memread=1, iord=0, alusrc_a=0, alusrc_b=1, aluop=00, pcsource=0.
  - irwrite and pcwrite are asserted only in a cycle where mem_ready=1; the FSM then moves to DECODE.
  - If mem_ready=0, the FSM holds in FETCH with no PC/IR write.
- DECODE: alusrc_a=0, alusrc_b=3, aluop=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi -> IEXEC
  - anything else -> FETCH, with illegal=1 for that cycle and instret not incremented.
- MEMADR: alusrc_a=1, alusrc_b=2, aluop=00. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready=1, then -> FETCH. Retires in the mem_ready cycle.
- EXEC: alusrc_a=1, alusrc_b=0, aluop=10 -> RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrc_a=1, alusrc_b=0, aluop=01, pcsource=1. pcwrite_eq=1 for beq, pcwrite_ne=1 for bne -> FETCH.
- JUMP: pcwrite=1, pcsource=2 -> FETCH.
- IEXEC: alusrc_a=1, alusrc_b=2, aluop=00 -> IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- The opcode is latched into an internal register in DECODE. Later states use the latched copy, so opcode changes after DECODE have no effect.
- Retirement: instret increments by 1 in the last cycle of each instruction, i.e. the cycle that transitions to FETCH (excluding the illegal path). It wraps modulo 2^CNT_W.
- Zero-wait cycle counts (fetch to fetch):
  - R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4.
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.
- memread and memwrite are never asserted in the same cycle. regwrite is never asserted in a memory-access state.

Test Plan:
- rst=1 for 2 cycles mid-lw (in MEMRD) -> state=0, instret=0, all strobes 0 during reset; the following fetch starts clean, with no regwrite from the abandoned lw.
- R-type (opcode 0x00), mem_ready tied 1 -> state sequence 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7; instret 0->1 after 4 cycles.
- lw (0x23) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with memread=1, iord=1; total 8 cycles; memtoreg=1 and regwrite=1 in state 4.
- beq (0x04) then bne (0x05) -> state 8 shows pcwrite_eq=1/pcwrite_ne=0, then pcwrite_eq=0/pcwrite_ne=1; aluop=01, pcsource=1; 3 cycles each.
- sw (0x2B), j (0x02), addi (0x08) back-to-back with zero wait -> 4+3+4 cycles, instret +3; memwrite exactly 1 cycle; pcsource=2 in JUMP.
- Opcode 0x3F in DECODE -> illegal=1 for one cycle, back to FETCH, instret unchanged. Separately, CNT_W=4 after 16 retirements -> instret wraps to 0.
